vga_timing_gen: RTL and testbench

Raster timing generator and pixel output stage driving the VGA connector. Scans a 1280x1024@60 frame, presents the current pixel coordinate as `x`/`y` to the cell-colouring logic, accepts the returned 12-bit colour, and registers it with blanking and sync onto the output pins. Also produces frame-boundary pulses used by the game engine to advance generations.

---
 rtl/vga_timing_gen.sv | 170 +++++++++++++++++
 tb/tb_vga_timing_gen.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Raster timing generator and pixel output stage for a 1280x1024@60 VGA frame.
// Free-running x/y counters present the current coordinate to the colouring
// logic. The returned colour is blanked outside the visible area and
// registered together with hsync/vsync, so colour and syncs always reach the
// pins with the same one-clock latency. Frame-boundary pulses drive the game
// engine's generation stepping.
//
// Optional feature macro: VGA_STEP_DIV_EN
//   defined   : `step` pulses once every STEP_FRAMES frame ticks seen while
//               `run`=1. The frame count is held while `run`=0.
//   undefined : `step` is a registered copy of (frame_tick & run).
//
// Ports
//   clk          in   pixel clock (single domain)
//   reset_n      in   synchronous, active-low reset
//   run          in   enables generation stepping
//   rgb_in       in   12-bit colour for the current x/y (combinational return)
//   x, y         out  horizontal / vertical counters (registered)
//   video_active out  x < H_VISIBLE && y < V_VISIBLE
//   vga_rgb      out  registered, blanked colour (R[11:8] G[7:4] B[3:0])
//   vga_hs       out  registered hsync, active level SYNC_POL
//   vga_vs       out  registered vsync, active level SYNC_POL
//   frame_tick   out  one-cycle pulse while on the last pixel of the frame
//   step         out  registered one-cycle generation-advance pulse
//
// Interface protocol: there is no valid/ready handshake. A coordinate is
// valid on every clock, and rgb_in must settle within that same cycle.
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int   H_VISIBLE = 1280,
  parameter int   H_FRONT   = 48,
  parameter int   H_SYNC    = 112,
  parameter int   H_BACK    = 248,
  parameter int   V_VISIBLE = 1024,
  parameter int   V_FRONT   = 1,
  parameter int   V_SYNC    = 3,
  parameter int   V_BACK    = 38,
  parameter logic SYNC_POL  = 1'b1
`ifdef VGA_STEP_DIV_EN
  ,
  parameter int   STEP_FRAMES = 30
`endif
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        run,
  input  logic [11:0] rgb_in,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        video_active,
  output logic [11:0] vga_rgb,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        frame_tick,
  output logic        step
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [10:0] r_x;
  logic [10:0] r_y;
  logic [11:0] r_rgb;
  logic        r_hs;
  logic        r_vs;
  logic        r_step;

  logic        w_x_last;
  logic        w_y_last;
  logic        w_active;
  logic        w_hs_on;
  logic        w_vs_on;
  logic        w_tick;

  // Decode of the current (registered) coordinate.
  always_comb begin
    w_x_last = (r_x == H_LAST);
    w_y_last = (r_y == V_LAST);
    w_active = (r_x < H_VIS) && (r_y < V_VIS);
    w_hs_on  = (r_x >= HS_START) && (r_x < HS_END);
    w_vs_on  = (r_y >= VS_START) && (r_y < VS_END);
    w_tick   = w_x_last && w_y_last;
  end

  // Raster counters: y advances only when x wraps.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_x_last) begin
      r_x <= '0;
      r_y <= w_y_last ? '0 : r_y + 11'd1;
    end else begin
      r_x <= r_x + 11'd1;
    end
  end

  // Output stage. Colour and syncs come from the same coordinate decode, so
  // they stay aligned at the pins.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rgb <= '0;
      r_hs  <= ~SYNC_POL;
      r_vs  <= ~SYNC_POL;
    end else begin
      r_rgb <= w_active ? rgb_in : 12'h000;
      r_hs  <= w_hs_on ? SYNC_POL : ~SYNC_POL;
      r_vs  <= w_vs_on ? SYNC_POL : ~SYNC_POL;
    end
  end

`ifdef VGA_STEP_DIV_EN
  // A STEP_FRAMES of 1 would give a zero-width counter, so the width is
  // clamped to one bit.
  localparam int DIV_W = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_FRAMES - 1);

  logic [DIV_W-1:0] r_div;

  // Counts frame ticks seen while run=1. The tick that finds the counter at
  // its last value clears the counter and fires step on the next cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_div  <= '0;
      r_step <= 1'b0;
    end else begin
      r_step <= 1'b0;
      if (w_tick && run) begin
        if (r_div == DIV_LAST) begin
          r_div  <= '0;
          r_step <= 1'b1;
        end else begin
          r_div <= r_div + 1'b1;
        end
      end
    end
  end
`else
  // One generation per frame.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_step <= 1'b0;
    end else begin
      r_step <= w_tick && run;
    end
  end
`endif

  assign x            = r_x;
  assign y            = r_y;
  assign video_active = w_active;
  assign vga_rgb      = r_rgb;
  assign vga_hs       = r_hs;
  assign vga_vs       = r_vs;
  assign frame_tick   = w_tick;
  assign step         = r_step;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Bench for vga_timing_gen using a shrunken raster, so that many whole frames
// fit in a short run. The reference model tracks the linear pixel index since
// reset and derives x/y, blanking, sync windows and step pulses from it
// arithmetically. On every clock edge it pushes the expected post-edge outputs
// into exp_q. A monitor pops from exp_q on the falling edge and compares.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_timing_gen;

  localparam int   HV = 16, HF = 2, HS = 3, HB = 4;
  localparam int   VV = 8,  VF = 1, VS = 2, VB = 3;
  localparam logic POL = 1'b1;
  localparam int   SF  = 3;
  localparam int   HT  = HV + HF + HS + HB;   // 25
  localparam int   VT  = VV + VF + VS + VB;   // 14
  localparam int   FT  = HT * VT;             // 350 clocks per frame

  // Packed expected record: {x, y, active, tick, rgb, hs, vs, step}
  localparam int EW = 11 + 11 + 1 + 1 + 12 + 1 + 1 + 1;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_n;
  logic        run;
  logic [11:0] rgb_in;

  logic [10:0] x, y;
  logic        video_active;
  logic [11:0] vga_rgb;
  logic        vga_hs, vga_vs, frame_tick, step;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POL(POL)
`ifdef VGA_STEP_DIV_EN
    , .STEP_FRAMES(SF)
`endif
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .run(run),
    .rgb_in(rgb_in),
    .x(x),
    .y(y),
    .video_active(video_active),
    .vga_rgb(vga_rgb),
    .vga_hs(vga_hs),
    .vga_vs(vga_vs),
    .frame_tick(frame_tick),
    .step(step)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_steps_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  // ---------------- reference model ----------------
  int m_pos = 0;        // linear pixel index within the frame
  int m_run_ticks = 0;  // frame ticks seen with run=1 since reset

  always @(posedge clk) begin
    int cx, cy, nx, ny;
    logic e_act, e_tick, e_hs, e_vs, e_step, c_act, c_tick;
    logic [11:0] e_rgb;
    if (!reset_n) begin
      m_pos = 0;
      m_run_ticks = 0;
      e_rgb  = 12'h000;
      e_hs   = ~POL;
      e_vs   = ~POL;
      e_step = 1'b0;
    end else begin
      cx = m_pos % HT;
      cy = m_pos / HT;
      c_act  = (cx < HV) && (cy < VV);
      c_tick = (m_pos == FT - 1);
      e_rgb  = c_act ? rgb_in : 12'h000;
      e_hs   = (cx >= HV + HF && cx < HV + HF + HS) ? POL : ~POL;
      e_vs   = (cy >= VV + VF && cy < VV + VF + VS) ? POL : ~POL;
`ifdef VGA_STEP_DIV_EN
      e_step = 1'b0;
      if (c_tick && run) begin
        m_run_ticks++;
        e_step = (m_run_ticks % SF) == 0;
      end
`else
      e_step = c_tick && run;
`endif
      m_pos = (m_pos + 1) % FT;
    end
    nx = m_pos % HT;
    ny = m_pos / HT;
    e_act  = (nx < HV) && (ny < VV);
    e_tick = (m_pos == FT - 1);
    exp_q.push_back({11'(nx), 11'(ny), e_act, e_tick, e_rgb, e_hs, e_vs, e_step});
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("x",            32'(x),            32'(e[38:28]));
      check("y",            32'(y),            32'(e[27:17]));
      check("video_active", 32'(video_active), 32'(e[16]));
      check("frame_tick",   32'(frame_tick),   32'(e[15]));
      check("vga_rgb",      32'(vga_rgb),      32'(e[14:3]));
      check("vga_hs",       32'(vga_hs),       32'(e[2]));
      check("vga_vs",       32'(vga_vs),       32'(e[1]));
      check("step",         32'(step),         32'(e[0]));
      if (step === 1'b1) n_steps_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_random(input int n);
    for (int i = 0; i < n; i++) begin
      rgb_in = 12'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic drive_const(input logic [11:0] c, input int n);
    for (int i = 0; i < n; i++) begin
      rgb_in = c;
      @(negedge clk);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0;
    run     = 1'b1;
    rgb_in  = 12'hABC;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Several full frames with random colour, stepping enabled.
    drive_random(4 * FT);

    // Constant red: visible pixels show F00, blanking shows 0.
    drive_const(12'hF00, FT);

    // Mid-frame single-clock reset, then scanning restarts from (0,0).
    drive_random(FT / 2 + int'($urandom_range(0, FT / 3)));
    reset_n = 1'b0;
    drive_random(1);
    reset_n = 1'b1;
    drive_random(2 * FT);

    // Stepping held off for five frames, then resumed.
    run = 1'b0;
    drive_random(5 * FT);
    run = 1'b1;
    drive_random(4 * FT);

    // Run toggled randomly frame by frame at a random phase.
    for (int i = 0; i < 6; i++) begin
      run = 1'($urandom_range(0, 1));
      drive_random(FT + int'($urandom_range(0, HT)));
    end

    drive_random(2);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("steps observed: %0d", n_steps_seen);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
